// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the neuron core scheduler and its state bank:
//   - IEEE-754 single-precision constants used as adder operands
//   - FSM state encoding of the timestep scheduler
//   - helpers that derive the neuron-id and refractory-counter widths
// Optional feature macro used by the files importing this package:
// REFRACTORY_EN.
// -----------------------------------------------------------------------------
package snn_pkg;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP_ZERO    = 32'h0000_0000;
    localparam fp32_t FP_POS_INF = 32'h7F80_0000;
    localparam fp32_t FP_ONE     = 32'h3F80_0000;

    // Scheduler FSM encoding
    localparam logic [1:0] ST_ACCUM = 2'd0;  // accumulate incoming weights
    localparam logic [1:0] ST_SWEEP = 2'd1;  // update one neuron per cycle
    localparam logic [1:0] ST_DRAIN = 2'd2;  // hold a spike until the NI takes it
    localparam logic [1:0] ST_DONE  = 2'd3;  // one-cycle end-of-timestep marker

    // Neuron-id width; a single neuron still needs one index bit.
    function automatic int nid_width(input int num_neurons);
        return (num_neurons < 2) ? 1 : $clog2(num_neurons);
    endfunction

    // Refractory counter width able to hold the value refrac_steps.
    function automatic int rc_width(input int refrac_steps);
        return (refrac_steps < 1) ? 1 : $clog2(refrac_steps + 1);
    endfunction

endpackage

// File: rtl/neuron_state_bank.sv
// -----------------------------------------------------------------------------
// neuron_state_bank
// Per-neuron register storage for the timestep scheduler: input-current
// accumulators (acc), membrane potentials (v) and, when REFRACTORY_EN is
// defined, refractory counters (rc). Every array has one combinational read
// port; all arrays share a single write index with a per-array enable.
// Reset clears every entry to zero.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   acc_rd_idx / acc_rd_data   accumulator read port
//   v_rd_idx / v_rd_data       potential read port
//   rc_rd_idx / rc_rd_data     refractory counter read port (REFRACTORY_EN)
//   wr_idx                     shared write index
//   wr_acc_en / wr_acc_data    accumulator write
//   wr_v_en / wr_v_data        potential write
//   wr_rc_en / wr_rc_data      refractory counter write (REFRACTORY_EN)
// -----------------------------------------------------------------------------
module neuron_state_bank
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int NID_W       = 3
`ifdef REFRACTORY_EN
    ,
    parameter int RC_W        = 2
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NID_W-1:0] acc_rd_idx,
    output logic [31:0]      acc_rd_data,
    input  logic [NID_W-1:0] v_rd_idx,
    output logic [31:0]      v_rd_data,
`ifdef REFRACTORY_EN
    input  logic [NID_W-1:0] rc_rd_idx,
    output logic [RC_W-1:0]  rc_rd_data,
    input  logic             wr_rc_en,
    input  logic [RC_W-1:0]  wr_rc_data,
`endif
    input  logic [NID_W-1:0] wr_idx,
    input  logic             wr_acc_en,
    input  logic [31:0]      wr_acc_data,
    input  logic             wr_v_en,
    input  logic [31:0]      wr_v_data
);

    fp32_t acc_q [NUM_NEURONS];
    fp32_t v_q   [NUM_NEURONS];
`ifdef REFRACTORY_EN
    logic [RC_W-1:0] rc_q [NUM_NEURONS];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_entry
            fp32_t acc_reg;
            fp32_t v_reg;
            logic  hit;

            assign hit = (wr_idx == NID_W'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    acc_reg <= FP_ZERO;
                    v_reg   <= FP_ZERO;
                end else begin
                    if (wr_acc_en && hit) begin
                        acc_reg <= wr_acc_data;
                    end
                    if (wr_v_en && hit) begin
                        v_reg <= wr_v_data;
                    end
                end
            end

            assign acc_q[gi] = acc_reg;
            assign v_q[gi]   = v_reg;

`ifdef REFRACTORY_EN
            logic [RC_W-1:0] rc_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rc_reg <= '0;
                end else if (wr_rc_en && hit) begin
                    rc_reg <= wr_rc_data;
                end
            end

            assign rc_q[gi] = rc_reg;
`endif
        end
    endgenerate

    assign acc_rd_data = acc_q[acc_rd_idx];
    assign v_rd_data   = v_q[v_rd_idx];
`ifdef REFRACTORY_EN
    assign rc_rd_data  = rc_q[rc_rd_idx];
`endif

endmodule

// File: rtl/neuron_timestep_scheduler.sv
// -----------------------------------------------------------------------------
// neuron_timestep_scheduler
// Time-multiplexes one shared floating-point potential adder across the
// neurons of a core. During a timestep (ACCUM) each accepted weight event is
// added into the target neuron's input-current accumulator. A ts_start pulse
// starts a sweep (SWEEP): each neuron's potential goes through the external
// decay unit, the accumulated current is added and the adder's threshold
// check decides whether the neuron spikes. Spikes are handed to the network
// interface one at a time (DRAIN) before the sweep continues. DONE pulses
// ts_done for one cycle and the core returns to ACCUM.
//
// Optional feature: define REFRACTORY_EN to give every neuron a refractory
// counter. A neuron that spiked ignores its accumulated current (and keeps
// its potential) for the next REFRAC_STEPS sweeps.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   ts_start                    end accumulation, start sweep (ACCUM only)
//   w_valid/w_ready/w_nid/w_weight   weight event handshake
//   v_threshold                 firing threshold, stable during a sweep
//   dec_in / dec_out            external combinational decay unit
//   add_weight/add_potential/add_threshold   shared adder operands
//   add_result / add_spike      shared adder result and spike flag
//   spike_valid/spike_ready/spike_nid        spike event handshake
//   ts_done                     one-cycle pulse at sweep completion
//   busy                        high while sweeping or draining a spike
// -----------------------------------------------------------------------------
module neuron_timestep_scheduler
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS  = 8,
    parameter int NID_W        = nid_width(NUM_NEURONS),
    parameter int REFRAC_STEPS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ts_start,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [NID_W-1:0] w_nid,
    input  logic [31:0]      w_weight,
    input  logic [31:0]      v_threshold,
    output logic [31:0]      dec_in,
    input  logic [31:0]      dec_out,
    output logic [31:0]      add_weight,
    output logic [31:0]      add_potential,
    output logic [31:0]      add_threshold,
    input  logic [31:0]      add_result,
    input  logic             add_spike,
    output logic             spike_valid,
    input  logic             spike_ready,
    output logic [NID_W-1:0] spike_nid,
    output logic             ts_done,
    output logic             busy
);

    localparam logic [NID_W-1:0] LAST_IDX = NID_W'(NUM_NEURONS - 1);

    generate
        if (NUM_NEURONS < 2 || NID_W != $clog2(NUM_NEURONS) || REFRAC_STEPS < 1) begin : g_cfg_check
            $error("neuron_timestep_scheduler: inconsistent parameters");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       state_reg, state_next;
    logic [NID_W-1:0] idx_reg, idx_next;
    logic             spike_valid_reg, spike_valid_next;
    logic [NID_W-1:0] spike_nid_reg, spike_nid_next;

    // State bank interface
    logic [NID_W-1:0] acc_rd_idx;
    fp32_t            acc_rd_data;
    fp32_t            v_rd_data;
    logic [NID_W-1:0] wr_idx;
    logic             wr_acc_en;
    fp32_t            wr_acc_data;
    logic             wr_v_en;
    fp32_t            wr_v_data;
    logic             refractory;

`ifdef REFRACTORY_EN
    localparam int              RC_W    = rc_width(REFRAC_STEPS);
    localparam logic [RC_W-1:0] RC_INIT = RC_W'(REFRAC_STEPS);

    logic [RC_W-1:0] rc_rd_data;
    logic            wr_rc_en;
    logic [RC_W-1:0] wr_rc_data;
`endif

    neuron_state_bank #(
        .NUM_NEURONS (NUM_NEURONS),
        .NID_W       (NID_W)
`ifdef REFRACTORY_EN
        ,
        .RC_W        (RC_W)
`endif
    ) u_bank (
        .clk         (clk),
        .reset       (reset),
        .acc_rd_idx  (acc_rd_idx),
        .acc_rd_data (acc_rd_data),
        .v_rd_idx    (idx_reg),
        .v_rd_data   (v_rd_data),
`ifdef REFRACTORY_EN
        .rc_rd_idx   (idx_reg),
        .rc_rd_data  (rc_rd_data),
        .wr_rc_en    (wr_rc_en),
        .wr_rc_data  (wr_rc_data),
`endif
        .wr_idx      (wr_idx),
        .wr_acc_en   (wr_acc_en),
        .wr_acc_data (wr_acc_data),
        .wr_v_en     (wr_v_en),
        .wr_v_data   (wr_v_data)
    );

`ifdef REFRACTORY_EN
    assign refractory = (rc_rd_data != '0);
`else
    assign refractory = 1'b0;
`endif

    // Accumulator read follows the incoming event while accumulating and the
    // sweep index otherwise.
    assign acc_rd_idx = (state_reg == ST_ACCUM) ? w_nid : idx_reg;

    // Status outputs decode directly from registered state.
    assign w_ready     = (state_reg == ST_ACCUM);
    assign busy        = (state_reg == ST_SWEEP) || (state_reg == ST_DRAIN);
    assign ts_done     = (state_reg == ST_DONE);
    assign spike_valid = spike_valid_reg;
    assign spike_nid   = spike_nid_reg;

    // -------------------------------------------------------------------------
    // Adder / decay operands. Kept apart from the control block below because
    // add_result and dec_out are combinational functions of these outputs.
    // -------------------------------------------------------------------------
    assign dec_in = (state_reg == ST_SWEEP) ? v_rd_data : FP_ZERO;

    always_comb begin
        add_weight    = FP_ZERO;
        add_potential = FP_ZERO;
        add_threshold = FP_ZERO;
        if (state_reg == ST_ACCUM && w_valid) begin
            // +inf threshold turns the adder into a plain accumulator.
            add_weight    = w_weight;
            add_potential = acc_rd_data;
            add_threshold = FP_POS_INF;
        end else if (state_reg == ST_SWEEP) begin
            add_weight    = acc_rd_data;
            add_potential = dec_out;
            add_threshold = v_threshold;
        end
    end

    // -------------------------------------------------------------------------
    // Control: bank writes and next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        spike_valid_next = spike_valid_reg;
        spike_nid_next   = spike_nid_reg;
        wr_idx           = idx_reg;
        wr_acc_en        = 1'b0;
        wr_acc_data      = FP_ZERO;
        wr_v_en          = 1'b0;
        wr_v_data        = FP_ZERO;
`ifdef REFRACTORY_EN
        wr_rc_en         = 1'b0;
        wr_rc_data       = '0;
`endif

        case (state_reg)
            ST_ACCUM: begin
                // A weight arriving together with ts_start is still counted.
                if (w_valid) begin
                    wr_idx      = w_nid;
                    wr_acc_en   = 1'b1;
                    wr_acc_data = add_result;
                end
                if (ts_start) begin
                    state_next = ST_SWEEP;
                    idx_next   = '0;
                end
            end

            ST_SWEEP: begin
                wr_acc_en   = 1'b1;
                wr_acc_data = FP_ZERO;
                if (refractory) begin
                    // Current is discarded; potential is left untouched.
`ifdef REFRACTORY_EN
                    wr_rc_en   = 1'b1;
                    wr_rc_data = rc_rd_data - 1'b1;
`endif
                end else begin
                    wr_v_en   = 1'b1;
                    wr_v_data = add_result;
`ifdef REFRACTORY_EN
                    if (add_spike) begin
                        wr_rc_en   = 1'b1;
                        wr_rc_data = RC_INIT;
                    end
`endif
                end

                if (add_spike && !refractory) begin
                    spike_valid_next = 1'b1;
                    spike_nid_next   = idx_reg;
                    state_next       = ST_DRAIN;
                end else if (idx_reg == LAST_IDX) begin
                    state_next = ST_DONE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end

            ST_DRAIN: begin
                if (spike_ready) begin
                    spike_valid_next = 1'b0;
                    if (idx_reg == LAST_IDX) begin
                        state_next = ST_DONE;
                        idx_next   = '0;
                    end else begin
                        state_next = ST_SWEEP;
                        idx_next   = idx_reg + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_next = ST_ACCUM;
                idx_next   = '0;
            end

            default: begin
                state_next = ST_ACCUM;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_ACCUM;
            idx_reg         <= '0;
            spike_valid_reg <= 1'b0;
            spike_nid_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            spike_valid_reg <= spike_valid_next;
            spike_nid_reg   <= spike_nid_next;
        end
    end

endmodule

// File: tb/tb_neuron_timestep_scheduler.sv
// -----------------------------------------------------------------------------
// tb_neuron_timestep_scheduler
// Self-checking bench for neuron_timestep_scheduler. The decay unit is an
// identity; the shared adder adds its operands and, when the sum reaches the
// threshold, raises add_spike and returns sum - threshold. A real-valued
// reference model of the neuron core predicts accumulators, potentials and
// the spike order of every sweep. Define REFRACTORY_EN for both DUT and bench
// to exercise the refractory feature.
// -----------------------------------------------------------------------------
module tb_neuron_timestep_scheduler;

    localparam int NN = 8;
    localparam int NW = 3;
`ifdef REFRACTORY_EN
    localparam int REFRAC = 2;
`else
    localparam int REFRAC = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ts_start = 1'b0;
    logic          w_valid = 1'b0;
    logic          w_ready;
    logic [NW-1:0] w_nid = '0;
    logic [31:0]   w_weight = '0;
    logic [31:0]   v_threshold = 32'h3F80_0000;
    logic [31:0]   dec_in, dec_out;
    logic [31:0]   add_weight, add_potential, add_threshold, add_result;
    logic          add_spike;
    logic          spike_valid;
    logic          spike_ready = 1'b0;
    logic [NW-1:0] spike_nid;
    logic          ts_done, busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    real m_acc [NN];
    real m_v   [NN];
    int  m_rc  [NN];

    // Results of the most recent sweep
    int last_spikes;
    int last_cycles;
    int last_first_nid;

    always #5 clk = ~clk;

    neuron_timestep_scheduler #(
        .NUM_NEURONS  (NN),
        .NID_W        (NW),
        .REFRAC_STEPS (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ts_start      (ts_start),
        .w_valid       (w_valid),
        .w_ready       (w_ready),
        .w_nid         (w_nid),
        .w_weight      (w_weight),
        .v_threshold   (v_threshold),
        .dec_in        (dec_in),
        .dec_out       (dec_out),
        .add_weight    (add_weight),
        .add_potential (add_potential),
        .add_threshold (add_threshold),
        .add_result    (add_result),
        .add_spike     (add_spike),
        .spike_valid   (spike_valid),
        .spike_ready   (spike_ready),
        .spike_nid     (spike_nid),
        .ts_done       (ts_done),
        .busy          (busy)
    );

    // float32 <-> real (normal numbers, zero and infinity)
    function automatic real f2r(input logic [31:0] b);
        logic [10:0] e;
        if (b[30:23] == 8'd0) return 0.0;
        if (b[30:23] == 8'hFF) e = 11'h7FF;
        else e = {3'b000, b[30:23]} + 11'd896;
        return $bitstoreal({b[31], e, b[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real x);
        logic [63:0] d;
        logic [10:0] e;
        if (x == 0.0) return 32'h0000_0000;
        d = $realtobits(x);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Environment: identity decay and a subtract-on-spike adder
    real env_sum, env_thr;
    always_comb begin
        dec_out    = dec_in;
        env_sum    = f2r(add_weight) + f2r(add_potential);
        env_thr    = f2r(add_threshold);
        add_spike  = (env_sum >= env_thr);
        add_result = add_spike ? r2f(env_sum - env_thr) : r2f(env_sum);
    end

    // -------------------------------------------------------------------------
    // Helpers (all start and end on a falling edge)
    // -------------------------------------------------------------------------
    task automatic reset_dut();
        reset = 1'b1; ts_start = 1'b0; w_valid = 1'b0; spike_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < NN; k++) begin
            m_acc[k] = 0.0; m_v[k] = 0.0; m_rc[k] = 0;
        end
    endtask

    task automatic send_weight(input int nid, input real w);
        w_valid = 1'b1; w_nid = NW'(nid); w_weight = r2f(w);
        #1;
        checks++;
        if (w_ready !== 1'b1) begin
            errors++; $display("FAIL w_ready_accum: got %b expected 1", w_ready);
        end
        checks++;
        if (add_potential !== r2f(m_acc[nid]) || add_threshold !== 32'h7F80_0000) begin
            errors++;
            $display("FAIL accum_operands nid=%0d: potential %h threshold %h expected %h %h",
                     nid, add_potential, add_threshold, r2f(m_acc[nid]), 32'h7F80_0000);
        end
        m_acc[nid] = m_acc[nid] + w;
        $display("weight nid=%0d w=%h acc_expected=%h", nid, r2f(w), r2f(m_acc[nid]));
        @(negedge clk);
        w_valid = 1'b0;
    endtask

    // Run one sweep, optionally with a weight in the ts_start cycle, and check
    // every swept neuron, every spike event, the latency and the status flags.
    task automatic do_sweep(input int stall, input bit with_w, input int wn, input real ww);
        real exp_w [NN];
        real exp_v [NN];
        int  exp_spk [$];
        real thr, p;
        int  cycles, sk, sp, hold;

        if (with_w) begin
            w_valid = 1'b1; w_nid = NW'(wn); w_weight = r2f(ww);
            #1;
            checks++;
            if (add_potential !== r2f(m_acc[wn])) begin
                errors++;
                $display("FAIL same_cycle_weight: potential %h expected %h", add_potential, r2f(m_acc[wn]));
            end
            m_acc[wn] = m_acc[wn] + ww;
        end
        ts_start = 1'b1;

        thr = f2r(v_threshold);
        for (int k = 0; k < NN; k++) begin
            exp_w[k] = m_acc[k];
            exp_v[k] = m_v[k];
            if (m_rc[k] > 0) begin
                m_rc[k]--;
            end else begin
                p = m_v[k] + m_acc[k];
                if (p >= thr) begin
                    exp_spk.push_back(k);
                    m_v[k]  = p - thr;
                    m_rc[k] = REFRAC;
                end else begin
                    m_v[k] = p;
                end
            end
            m_acc[k] = 0.0;
        end

        @(negedge clk);
        ts_start = 1'b0; w_valid = 1'b0;
        cycles = 1; sk = 0; sp = 0; hold = 0; last_first_nid = -1;
        while (ts_done !== 1'b1 && cycles < 300) begin
            checks++;
            if (w_ready !== 1'b0) begin
                errors++; $display("FAIL w_ready_sweep: got %b expected 0 (cycle %0d)", w_ready, cycles);
            end
            if (spike_valid === 1'b1) begin
                checks++;
                if (sp >= exp_spk.size()) begin
                    errors++; $display("FAIL spike_extra: got nid %0d, expected no more spikes", spike_nid);
                end else if (spike_nid !== NW'(exp_spk[sp])) begin
                    errors++; $display("FAIL spike_nid: got %0d expected %0d", spike_nid, exp_spk[sp]);
                end
                if (last_first_nid < 0) last_first_nid = int'(spike_nid);
                if (hold < stall) begin
                    spike_ready = 1'b0; hold++;
                end else begin
                    spike_ready = 1'b1; hold = 0; sp++;
                end
            end else if (busy === 1'b1) begin
                spike_ready = 1'b0;
                checks++;
                if (sk >= NN) begin
                    errors++; $display("FAIL sweep_extra: more than %0d sweep cycles", NN);
                end else if (add_weight !== r2f(exp_w[sk]) || dec_in !== r2f(exp_v[sk])) begin
                    errors++;
                    $display("FAIL sweep_neuron %0d: acc %h v %h expected %h %h",
                             sk, add_weight, dec_in, r2f(exp_w[sk]), r2f(exp_v[sk]));
                end
                sk++;
            end
            @(negedge clk);
            cycles++;
        end
        spike_ready = 1'b0;
        last_spikes = sp;
        last_cycles = cycles;

        checks++;
        if (ts_done !== 1'b1) begin
            errors++; $display("FAIL sweep_timeout: ts_done %b after %0d cycles, expected 1", ts_done, cycles);
        end
        checks++;
        if (cycles != NN + 1 + exp_spk.size() * (1 + stall) || sk != NN || sp != exp_spk.size()) begin
            errors++;
            $display("FAIL sweep_latency: cycles %0d neurons %0d spikes %0d expected %0d %0d %0d",
                     cycles, sk, sp, NN + 1 + exp_spk.size() * (1 + stall), NN, exp_spk.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL busy_done: got %b expected 0", busy);
        end
        $display("sweep stall=%0d spikes=%0d cycles=%0d", stall, sp, cycles);
        @(negedge clk);
        checks++;
        if (ts_done !== 1'b0 || w_ready !== 1'b1) begin
            errors++; $display("FAIL after_done: ts_done %b w_ready %b expected 0 1", ts_done, w_ready);
        end
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset_dut();
        checks++;
        if (w_ready !== 1'b1 || busy !== 1'b0 || spike_valid !== 1'b0 || ts_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: w_ready %b busy %b spike_valid %b ts_done %b expected 1 0 0 0",
                     w_ready, busy, spike_valid, ts_done);
        end
        checks++;
        if (add_weight !== 32'h0 || add_potential !== 32'h0 || add_threshold !== 32'h0 || dec_in !== 32'h0) begin
            errors++;
            $display("FAIL reset_operands: %h %h %h %h expected all 0",
                     add_weight, add_potential, add_threshold, dec_in);
        end
        $display("reset checked");
    endtask

    task automatic test_basic_spike();
        reset_dut();
        v_threshold = 32'h3F80_0000;
        send_weight(2, 0.5);
        send_weight(2, 0.5);
        do_sweep(0, 1'b0, 0, 0.0);
        checks++;
        if (last_spikes != 1 || last_first_nid != 2 || last_cycles != 10) begin
            errors++;
            $display("FAIL basic_spike: spikes %0d nid %0d cycles %0d expected 1 2 10",
                     last_spikes, last_first_nid, last_cycles);
        end
        do_sweep(0, 1'b0, 0, 0.0);
    endtask

    task automatic test_drain_stall();
        reset_dut();
        v_threshold = 32'h3F80_0000;
        send_weight(0, 1.5);
        send_weight(7, 1.5);
        do_sweep(5, 1'b0, 0, 0.0);
        checks++;
        if (last_spikes != 2 || last_first_nid != 0 || last_cycles != 21) begin
            errors++;
            $display("FAIL drain_stall: spikes %0d first %0d cycles %0d expected 2 0 21",
                     last_spikes, last_first_nid, last_cycles);
        end
        // Next sweep exposes v[0]=v[7]=0.5 and untouched neighbours.
        do_sweep(0, 1'b0, 0, 0.0);
        checks++;
        if (last_spikes != 0) begin
            errors++; $display("FAIL drain_followup: spikes %0d expected 0", last_spikes);
        end
    endtask

    task automatic test_same_cycle();
        reset_dut();
        v_threshold = 32'h3F80_0000;
        do_sweep(0, 1'b1, 1, 2.0);
        checks++;
        if (last_spikes != 1 || last_first_nid != 1) begin
            errors++; $display("FAIL same_cycle_spike: spikes %0d nid %0d expected 1 1", last_spikes, last_first_nid);
        end
    endtask

    task automatic test_reset_drain();
        int n;
        reset_dut();
        v_threshold = 32'h3F80_0000;
        send_weight(4, 1.5);
        send_weight(6, 0.25);
        ts_start = 1'b1;
        @(negedge clk);
        ts_start = 1'b0;
        n = 0;
        while (spike_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (spike_valid !== 1'b1 || spike_nid !== NW'(4)) begin
            errors++; $display("FAIL reach_drain: spike_valid %b nid %0d expected 1 4", spike_valid, spike_nid);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (spike_valid !== 1'b0 || busy !== 1'b0 || w_ready !== 1'b1 || ts_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_drain: spike_valid %b busy %b w_ready %b ts_done %b expected 0 0 1 0",
                     spike_valid, busy, w_ready, ts_done);
        end
        for (int k = 0; k < NN; k++) begin
            m_acc[k] = 0.0; m_v[k] = 0.0; m_rc[k] = 0;
        end
        $display("reset during drain");
        do_sweep(0, 1'b0, 0, 0.0);
        checks++;
        if (last_spikes != 0) begin
            errors++; $display("FAIL post_reset_sweep: spikes %0d expected 0", last_spikes);
        end
    endtask

    task automatic test_refractory();
        int exp_cnt [4];
`ifdef REFRACTORY_EN
        exp_cnt = '{1, 0, 0, 1};
`else
        exp_cnt = '{1, 1, 1, 1};
`endif
        reset_dut();
        v_threshold = 32'h3F80_0000;
        for (int t = 0; t < 4; t++) begin
            send_weight(3, 1.5);
            do_sweep(0, 1'b0, 0, 0.0);
            checks++;
            if (last_spikes != exp_cnt[t]) begin
                errors++; $display("FAIL refractory_step%0d: spikes %0d expected %0d", t + 1, last_spikes, exp_cnt[t]);
            end
        end
    endtask

    task automatic test_random();
        real wtab [8];
        real ttab [3];
        wtab = '{0.25, 0.5, 0.75, 1.0, 1.25, -0.5, -0.25, 2.0};
        ttab = '{3.0, 4.0, 8.0};
        reset_dut();
        for (int t = 0; t < 4; t++) begin
            v_threshold = r2f(ttab[$urandom_range(0, 2)]);
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                send_weight(int'($urandom_range(0, NN - 1)), wtab[$urandom_range(0, 7)]);
            end
            do_sweep(int'($urandom_range(0, 2)), 1'b0, 0, 0.0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_spike();
        test_drain_stall();
        test_same_cycle();
        test_reset_drain();
        test_refractory();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
